// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int          RST_LEN     = 4;
  localparam logic [31:0] RST_PATTERN = 32'h0000_000B;
  localparam logic        RST_OVERLAP = 1'b1;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational prefix matcher: longest pattern prefix ending at the newest bit,
// plus the longest proper prefix (border) for overlapping restarts.
module seq_prefix_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] i_hist,
  input  logic [LEN_W-1:0]   i_fill,
  input  logic               i_b,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic [LEN_W-1:0]   o_k,
  output logic [LEN_W-1:0]   o_j
);

  logic [MAX_LEN:0]   w_ext;
  logic [MAX_LEN-1:0] w_pat_al;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN:0]   w_mask;
  logic               w_ok;

  // Newest bit lands at index 0; the pattern is left-aligned so its first bit sits at MAX_LEN-1.
  assign w_ext    = {i_hist, i_b};
  assign w_pat_al = i_pattern << (MAX_LEN - int'(i_len));
  assign w_fill_n = (int'(i_fill) < MAX_LEN) ? i_fill + LEN_W'(1) : i_fill;

  always_comb begin
    o_k    = '0;
    o_j    = '0;
    w_mask = '0;
    w_ok   = 1'b0;
    for (int n = 1; n <= MAX_LEN; n++) begin
      w_mask = ~({(MAX_LEN+1){1'b1}} << n);
      w_ok   = (n <= int'(w_fill_n)) &&
               (((MAX_LEN+1)'(w_pat_al >> (MAX_LEN - n)) & w_mask) == (w_ext & w_mask));
      if (w_ok && (n <= int'(i_len))) o_k = LEN_W'(n);
      if (w_ok && (n <  int'(i_len))) o_j = LEN_W'(n);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial-pattern detector with runtime pattern/length/overlap, valid-qualified
// input, saturating match counter and exposed match progress.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               x_valid,
  input  logic               x,
  output logic               y,
  output logic [LEN_W-1:0]   st,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   r_st;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;

  logic [LEN_W-1:0]   w_k;
  logic [LEN_W-1:0]   w_j;
  logic               w_en;
  logic               w_y;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [CNT_W-1:0]   w_cnt_inc;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (int'(len) > MAX_LEN) return LEN_W'(MAX_LEN);
    return len;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  seq_prefix_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .i_hist    (r_hist),
    .i_fill    (r_fill),
    .i_b       (x),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_k       (w_k),
    .o_j       (w_j)
  );

  // A zero length disables detection entirely, so history and st stay put.
  assign w_en      = x_valid && !cfg_load && (r_len != '0);
  assign w_y       = w_en && !rst && (w_k == r_len);
  assign w_hist_n  = {r_hist[MAX_LEN-2:0], x};
  assign w_fill_n  = (int'(r_fill) < MAX_LEN) ? r_fill + LEN_W'(1) : r_fill;
  assign w_cnt_inc = sat_inc(r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= MAX_LEN'(RST_PATTERN);
      r_len     <= clamp_len(LEN_W'(RST_LEN));
      r_overlap <= RST_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_st      <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_len     <= clamp_len(cfg_len);
      r_overlap <= cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_st      <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
    end else if (w_en) begin
      if (w_y) begin
        r_cnt <= w_cnt_inc;
        r_sat <= &w_cnt_inc;
        if (r_overlap) begin
          r_st   <= w_j;
          r_hist <= w_hist_n;
          r_fill <= w_fill_n;
        end else begin
          // Non-overlapping: the matching bit is consumed, detection starts afresh.
          r_st   <= '0;
          r_hist <= '0;
          r_fill <= '0;
        end
      end else begin
        r_st   <= w_k;
        r_hist <= w_hist_n;
        r_fill <= w_fill_n;
      end
    end
  end

  assign y         = w_y;
  assign st        = r_st;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param (2-bit counter so saturation is reachable).
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               x_valid;
  logic               x;
  logic               y;
  logic [LEN_W-1:0]   st;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  typedef struct {
    logic             y;
    logic [LEN_W-1:0] st;
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .x_valid     (x_valid),
    .x           (x),
    .y           (y),
    .st          (st),
    .match_cnt   (match_cnt),
    .cnt_sat     (cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one stream cycle; expected outputs go into the scoreboard at drive time.
  task automatic step(input string tag, input logic v, input logic b,
                      input logic ey, input int est, input int ecnt, input logic esat);
    exp_t e;
    @(negedge clk);
    x_valid = v;
    x       = b;
    e.y   = ey;
    e.st  = LEN_W'(est);
    e.cnt = CNT_W'(ecnt);
    e.sat = esat;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({tag, ".y"}, 32'(y), 32'(e.y));
    @(posedge clk);
    #1;
    chk({tag, ".st"},  32'(st),        32'(e.st));
    chk({tag, ".cnt"}, 32'(match_cnt), 32'(e.cnt));
    chk({tag, ".sat"}, 32'(cnt_sat),   32'(e.sat));
  endtask

  task automatic restart(input string tag, input logic do_rst,
                         input logic [MAX_LEN-1:0] p, input int l, input logic o);
    @(negedge clk);
    rst         = do_rst;
    cfg_load    = !do_rst;
    cfg_pattern = p;
    cfg_len     = LEN_W'(l);
    cfg_overlap = o;
    x_valid     = 1'b1;
    x           = 1'b1;
    #1;
    chk({tag, ".y"}, 32'(y), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cfg_load = 1'b0;
    x_valid  = 1'b0;
    chk({tag, ".st"},  32'(st),        32'd0);
    chk({tag, ".cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, ".sat"}, 32'(cnt_sat),   32'd0);
  endtask

  initial begin
    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; x_valid = 1'b0; x = 1'b0;

    // Reset loads 1011/len4/overlap; cfg_* presented at reset must be ignored.
    restart("rst0", 1'b1, 8'h00, 1, 1'b0);

    // Default overlapping 1011
    step("t1b1", 1, 1, 0, 1, 0, 0);
    step("t1b2", 1, 0, 0, 2, 0, 0);
    step("t1b3", 1, 1, 0, 3, 0, 0);
    step("t1b4", 1, 1, 1, 1, 1, 0);
    step("t1b5", 1, 0, 0, 2, 1, 0);
    step("t1b6", 1, 1, 0, 3, 1, 0);
    step("t1b7", 1, 1, 1, 1, 2, 0);

    // Non-overlapping 1011
    restart("ld2", 1'b0, 8'h0B, 4, 1'b0);
    step("t2b1", 1, 1, 0, 1, 0, 0);
    step("t2b2", 1, 0, 0, 2, 0, 0);
    step("t2b3", 1, 1, 0, 3, 0, 0);
    step("t2b4", 1, 1, 1, 0, 1, 0);
    step("t2b5", 1, 0, 0, 0, 1, 0);
    step("t2b6", 1, 1, 0, 1, 1, 0);
    step("t2b7", 1, 1, 0, 1, 1, 0);

    // 111 overlapping: counter reaches all-ones on the third match
    restart("ld3a", 1'b0, 8'h07, 3, 1'b1);
    step("t3ab1", 1, 1, 0, 1, 0, 0);
    step("t3ab2", 1, 1, 0, 2, 0, 0);
    step("t3ab3", 1, 1, 1, 2, 1, 0);
    step("t3ab4", 1, 1, 1, 2, 2, 0);
    step("t3ab5", 1, 1, 1, 2, 3, 1);

    // 111 non-overlapping
    restart("ld3b", 1'b0, 8'h07, 3, 1'b0);
    step("t3bb1", 1, 1, 0, 1, 0, 0);
    step("t3bb2", 1, 1, 0, 2, 0, 0);
    step("t3bb3", 1, 1, 1, 0, 1, 0);
    step("t3bb4", 1, 1, 0, 1, 1, 0);
    step("t3bb5", 1, 1, 0, 2, 1, 0);

    // Idle cycles with x=1 must not match or disturb the partial match
    restart("ld4", 1'b0, 8'h0B, 4, 1'b1);
    step("t4b1", 1, 1, 0, 1, 0, 0);
    step("t4b2", 1, 0, 0, 2, 0, 0);
    step("t4b3", 1, 1, 0, 3, 0, 0);
    for (int i = 0; i < 5; i++) step("t4idle", 0, 1, 0, 3, 0, 0);
    step("t4b4", 1, 1, 1, 1, 1, 0);

    // Partial match then reset mid-stream
    step("t5a", 1, 0, 0, 2, 1, 0);
    step("t5b", 1, 1, 0, 3, 1, 0);
    restart("rst5", 1'b1, 8'hFF, 2, 1'b0);
    step("t5c1", 1, 1, 0, 1, 0, 0);
    step("t5c2", 1, 1, 0, 1, 0, 0);
    step("t5c3", 1, 1, 0, 1, 0, 0);
    step("t5c4", 1, 0, 0, 2, 0, 0);
    step("t5c5", 1, 1, 0, 3, 0, 0);
    step("t5c6", 1, 1, 1, 1, 1, 0);

    // Single-bit pattern: match every 1, counter saturates at 3
    restart("ld6", 1'b0, 8'h01, 1, 1'b1);
    step("t6b1", 1, 1, 1, 0, 1, 0);
    step("t6b2", 1, 1, 1, 0, 2, 0);
    step("t6b3", 1, 1, 1, 0, 3, 1);
    for (int i = 0; i < 4; i++) step("t6sat", 1, 1, 1, 0, 3, 1);
    step("t6zero", 1, 0, 0, 0, 3, 1);

    // Length above MAX_LEN clamps to 8
    restart("ld7", 1'b0, 8'hFF, 9, 1'b0);
    for (int i = 1; i <= 7; i++) step("t7fill", 1, 1, 0, i, 0, 0);
    step("t7hit", 1, 1, 1, 0, 1, 0);
    step("t7nxt", 1, 1, 0, 1, 1, 0);

    // Zero length disables detection
    restart("ld8", 1'b0, 8'h01, 0, 1'b1);
    for (int i = 0; i < 3; i++) step("t8off", 1, 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
